// File: rtl/led_fade_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_fade_ctrl_if
//   Control/status bundle for the LED fade sequencer.
//   master : drives start/stop/mode/target/step_div, observes status
//   slave  : the sequencer itself
//   Signals:
//     start    - single-cycle sequence request (captures mode/target)
//     stop     - single-cycle abort
//     mode     - 00 fade up, 01 fade down, 10 breathe, 11 jump
//     target   - end level for fade/jump modes
//     step_div - PWM frames per level step (0 behaves as 1)
//     level    - brightness level currently applied
//     pwm_out  - registered LED drive
//     busy     - sequence active
//     done     - single-cycle completion pulse
// ---------------------------------------------------------------------------
interface led_fade_ctrl_if #(
   parameter int DIV_W = 16
);
   logic             start;
   logic             stop;
   logic [1:0]       mode;
   logic [3:0]       target;
   logic [DIV_W-1:0] step_div;
   logic [3:0]       level;
   logic             pwm_out;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, mode, target, step_div,
      input  level, pwm_out, busy, done
   );

   modport slave (
      input  start, stop, mode, target, step_div,
      output level, pwm_out, busy, done
   );
endinterface

// File: rtl/led_fade_ctrl.sv
// ---------------------------------------------------------------------------
// led_fade_ctrl
//   Single-LED dimmer: 16-cycle PWM frame plus a sequencer that steps the
//   brightness level to fade up, fade down, breathe, or jump. Level changes
//   land only on frame boundaries (ctr 15->0) so no frame is ever truncated.
//   Ports:
//     CLK  - system clock
//     RST  - asynchronous active-high reset
//     bus  - led_fade_ctrl_if.slave (start/stop/mode/target/step_div in,
//            level/pwm_out/busy/done out)
//   Build option:
//     LED_FADE_GAMMA_EN - when defined, PWM compares against a gamma-mapped
//                         level; the level output stays linear.
// ---------------------------------------------------------------------------
module led_fade_ctrl #(
   parameter int DIV_W = 16
) (
   input  logic           CLK,
   input  logic           RST,
   led_fade_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       ctr_q, ctr_d;
   logic [DIV_W-1:0] fcnt_q, fcnt_d;
   logic [3:0]       level_q, level_d;
   logic [3:0]       tgt_q, tgt_d;
   logic             brth_q, brth_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pwm_q, pwm_d;

   logic             frame_end;
   logic             step_now;
   logic [DIV_W-1:0] div_last;
   logic [3:0]       cmp;

   // Last cycle of the frame: the next edge is the frame boundary.
   assign frame_end = (ctr_q == 4'd15);

   // Frame count at which a step is taken; step_div of 0 behaves as 1.
   assign div_last = (bus.step_div == '0) ? '0 : bus.step_div - DIV_W'(1);

   // >= rather than == so a step_div lowered mid-sequence cannot strand fcnt.
   assign step_now = frame_end && (fcnt_q >= div_last);

`ifdef LED_FADE_GAMMA_EN
   always_comb begin
      case (level_q)
         4'd0, 4'd1, 4'd2:   cmp = 4'd0;
         4'd3, 4'd4, 4'd5:   cmp = 4'd1;
         4'd6, 4'd7:         cmp = 4'd2;
         4'd8:               cmp = 4'd3;
         4'd9:               cmp = 4'd4;
         4'd10:              cmp = 4'd5;
         4'd11:              cmp = 4'd6;
         4'd12:              cmp = 4'd8;
         4'd13:              cmp = 4'd10;
         4'd14:              cmp = 4'd12;
         default:            cmp = 4'd15;
      endcase
   end
`else
   assign cmp = level_q;
`endif

   always_comb begin
      ctr_d   = ctr_q + 4'd1;
      // Compare against the level in force for this ctr value; pwm_out
      // therefore trails ctr by one register stage.
      pwm_d   = (ctr_q < cmp);
      state_d = state_q;
      fcnt_d  = fcnt_q;
      level_d = level_q;
      tgt_d   = tgt_q;
      brth_d  = brth_q;
      done_d  = 1'b0;

      if (bus.stop) begin
         // Abort wins over start and over any step due this edge.
         state_d = S_IDLE;
         brth_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  tgt_d  = bus.target;
                  fcnt_d = '0;
                  brth_d = 1'b0;
                  case (bus.mode)
                     2'b00: state_d = S_UP;
                     2'b01: state_d = S_DOWN;
                     2'b10: begin
                        state_d = S_UP;
                        tgt_d   = 4'd15;
                        brth_d  = 1'b1;
                     end
                     default: state_d = S_HOLD;
                  endcase
               end
            end

            S_UP: begin
               if (step_now) begin
                  fcnt_d = '0;
                  if (level_q < tgt_q) begin
                     level_d = level_q + 4'd1;
                  end else if (brth_q) begin
                     state_d = S_DOWN;
                     tgt_d   = 4'd0;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else if (frame_end) begin
                  fcnt_d = fcnt_q + DIV_W'(1);
               end
            end

            S_DOWN: begin
               if (step_now) begin
                  fcnt_d = '0;
                  if (level_q > tgt_q) begin
                     level_d = level_q - 4'd1;
                  end else if (brth_q) begin
                     state_d = S_UP;
                     tgt_d   = 4'd15;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else if (frame_end) begin
                  fcnt_d = fcnt_q + DIV_W'(1);
               end
            end

            default: begin // S_HOLD
               if (frame_end) begin
                  level_d = tgt_q;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         ctr_q   <= '0;
         fcnt_q  <= '0;
         level_q <= '0;
         tgt_q   <= '0;
         brth_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pwm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         fcnt_q  <= fcnt_d;
         level_q <= level_d;
         tgt_q   <= tgt_d;
         brth_q  <= brth_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pwm_q   <= pwm_d;
      end
   end

   assign bus.level   = level_q;
   assign bus.pwm_out = pwm_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
